// File: rtl/rgb_pwm_driver.sv
// Three-channel PWM output stage with double-buffered duties and an
// enable/drain FSM so the wheel never truncates a period on start or stop.
module rgb_pwm_driver #(
    parameter int PWM_INTERVAL = 1200,
    parameter bit ACTIVE_LOW   = 1'b1,
    parameter int DW           = $clog2(PWM_INTERVAL)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          enable,
    input  logic [DW-1:0] duty_r,
    input  logic [DW-1:0] duty_g,
    input  logic [DW-1:0] duty_b,
    output logic          led_r,
    output logic          led_g,
    output logic          led_b,
    output logic          period_start,
    output logic          busy
);

    localparam logic [1:0]    ST_IDLE   = 2'd0;
    localparam logic [1:0]    ST_RUN    = 2'd1;
    localparam logic [1:0]    ST_DRAIN  = 2'd2;
    localparam logic [DW-1:0] CNT_LAST  = DW'(PWM_INTERVAL - 1);
    localparam logic [DW-1:0] CNT_ONE   = DW'(1);
    localparam logic [DW:0]   DUTY_FULL = (DW+1)'(PWM_INTERVAL);

    // Shadows carry one extra bit so a full-period duty is representable
    // even when PWM_INTERVAL is a power of two.
    function automatic logic [DW:0] clamp_duty(input logic [DW-1:0] d);
        logic [DW:0] d_ext;
        d_ext = {1'b0, d};
        if (d_ext < DUTY_FULL) begin
            clamp_duty = d_ext;
        end else begin
            clamp_duty = DUTY_FULL;
        end
    endfunction

    logic [1:0]    state_r;
    logic [1:0]    state_nxt_s;
    logic [DW-1:0] cnt_r;
    logic [DW:0]   shadow_red_r;
    logic [DW:0]   shadow_grn_r;
    logic [DW:0]   shadow_blu_r;
    logic          wrap_s;
    logic          active_s;
    logic          load_s;

    assign wrap_s   = (cnt_r == CNT_LAST);
    assign active_s = (state_r != ST_IDLE);
    assign busy     = active_s;
    // Shadows refresh on IDLE->RUN entry and on any wrap that keeps the PWM going.
    assign load_s   = ((state_r == ST_IDLE) && (state_nxt_s == ST_RUN)) ||
                      (active_s && wrap_s && (state_nxt_s != ST_IDLE));

    // Next-state logic for the enable/drain controller.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (enable) state_nxt_s = ST_RUN;
                else        state_nxt_s = ST_IDLE;
            end
            ST_RUN: begin
                if (enable) state_nxt_s = ST_RUN;
                else        state_nxt_s = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (enable)      state_nxt_s = ST_RUN;
                else if (wrap_s) state_nxt_s = ST_IDLE;
                else             state_nxt_s = ST_DRAIN;
            end
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_r <= ST_IDLE;
        else     state_r <= state_nxt_s;
    end

    // Period counter: held at zero while idle, wraps at the period end.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_r <= {DW{1'b0}};
        end else if (!active_s || wrap_s || (state_nxt_s == ST_IDLE)) begin
            cnt_r <= {DW{1'b0}};
        end else begin
            cnt_r <= cnt_r + CNT_ONE;
        end
    end

    // Duty shadow registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shadow_red_r <= {(DW+1){1'b0}};
            shadow_grn_r <= {(DW+1){1'b0}};
            shadow_blu_r <= {(DW+1){1'b0}};
        end else if (load_s) begin
            shadow_red_r <= clamp_duty(duty_r);
            shadow_grn_r <= clamp_duty(duty_g);
            shadow_blu_r <= clamp_duty(duty_b);
        end else begin
            shadow_red_r <= shadow_red_r;
            shadow_grn_r <= shadow_grn_r;
            shadow_blu_r <= shadow_blu_r;
        end
    end

    // Registered pin drivers and period strobe.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            led_r        <= ACTIVE_LOW;
            led_g        <= ACTIVE_LOW;
            led_b        <= ACTIVE_LOW;
            period_start <= 1'b0;
        end else begin
            led_r        <= (active_s && ({1'b0, cnt_r} < shadow_red_r)) ^ ACTIVE_LOW;
            led_g        <= (active_s && ({1'b0, cnt_r} < shadow_grn_r)) ^ ACTIVE_LOW;
            led_b        <= (active_s && ({1'b0, cnt_r} < shadow_blu_r)) ^ ACTIVE_LOW;
            period_start <= active_s && (cnt_r == {DW{1'b0}});
        end
    end

endmodule

// File: tb/tb_rgb_pwm_driver.sv
// Self-checking bench for rgb_pwm_driver: directed scenarios plus random
// enable/duty traffic, compared against a period-level reference model.
module tb_rgb_pwm_driver;

    localparam int P  = 10;
    localparam int DW = $clog2(P);

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          enable = 1'b0;
    logic [DW-1:0] duty_r = '0;
    logic [DW-1:0] duty_g = '0;
    logic [DW-1:0] duty_b = '0;
    logic          led_r, led_g, led_b, period_start, busy;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: "inside a period" flag, position in the period,
    // latched duties, and the enable seen one cycle earlier.
    bit m_act;
    int m_pos;
    int m_sh [3];
    bit m_prev_en;
    bit e_led [3];
    bit e_ps;

    rgb_pwm_driver #(.PWM_INTERVAL(P), .ACTIVE_LOW(1'b1)) dut (
        .clk(clk), .rst(rst), .enable(enable),
        .duty_r(duty_r), .duty_g(duty_g), .duty_b(duty_b),
        .led_r(led_r), .led_g(led_g), .led_b(led_b),
        .period_start(period_start), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, obs, exp);
        end
    endtask

    function automatic int clampd(input int d);
        return (d < P) ? d : P;
    endfunction

    function automatic void model_reset();
        m_act = 1'b0; m_pos = 0; m_prev_en = 1'b0;
        for (int k = 0; k < 3; k++) begin
            m_sh[k] = 0; e_led[k] = 1'b1;
        end
        e_ps = 1'b0;
    endfunction

    // A period continues into the next one if enable was high in either of
    // its last two cycles; otherwise the engine stops after this period.
    function automatic void model_step(input bit e, input int r, input int g, input int b);
        for (int k = 0; k < 3; k++) e_led[k] = (m_act && (m_pos < m_sh[k])) ? 1'b0 : 1'b1;
        e_ps = m_act && (m_pos == 0);
        if (!m_act) begin
            if (e) begin
                m_act = 1'b1; m_pos = 0;
                m_sh[0] = clampd(r); m_sh[1] = clampd(g); m_sh[2] = clampd(b);
            end
        end else if (m_pos == P - 1) begin
            m_pos = 0;
            if (e || m_prev_en) begin
                m_sh[0] = clampd(r); m_sh[1] = clampd(g); m_sh[2] = clampd(b);
            end else begin
                m_act = 1'b0;
            end
        end else begin
            m_pos++;
        end
        m_prev_en = e;
    endfunction

    task automatic check_outputs();
        chk("led_r", led_r, e_led[0]);
        chk("led_g", led_g, e_led[1]);
        chk("led_b", led_b, e_led[2]);
        chk("period_start", period_start, e_ps);
        chk("busy", busy, m_act);
    endtask

    // One clock cycle: check outputs, drive inputs, advance model to next negedge.
    task automatic step(input bit e, input int r, input int g, input int b);
        check_outputs();
        enable = e;
        duty_r = DW'(r); duty_g = DW'(g); duty_b = DW'(b);
        model_step(e, r, g, b);
        @(negedge clk);
    endtask

    task automatic run_to_pos(input int pos, input int r, input int g, input int b);
        for (int i = 0; i < 2 * P && !(m_act && m_pos == pos); i++) step(1'b1, r, g, b);
        chk("reach_pos", m_pos, pos);
    endtask

    initial begin
        int r, g, b;
        bit e;
        model_reset();
        @(negedge clk);
        check_outputs();
        rst = 1'b0;
        for (int i = 0; i < 3; i++) step(1'b0, 0, 0, 0);

        // Basic run: r=3, g=0, b=full
        for (int i = 0; i < 25; i++) step(1'b1, 3, 0, 10);

        // Mid-period duty change only takes effect on the next period
        run_to_pos(4, 3, 0, 10);
        for (int i = 0; i < 20; i++) step(1'b1, 7, 0, 10);

        // Over-range duty clamps to a full period
        for (int i = 0; i < 20; i++) step(1'b1, 7, 15, 10);

        // Drop enable mid-period, let it drain, then restart
        run_to_pos(2, 7, 15, 10);
        for (int i = 0; i < 15; i++) step(1'b0, 7, 15, 10);
        for (int i = 0; i < 15; i++) step(1'b1, 5, 2, 9);

        // One-cycle enable glitch within a period
        run_to_pos(5, 5, 2, 9);
        step(1'b0, 5, 2, 9);
        for (int i = 0; i < 15; i++) step(1'b1, 5, 2, 9);

        // Enable dropped exactly on the wrap cycle: one more draining period
        run_to_pos(P - 1, 4, 6, 1);
        for (int i = 0; i < 25; i++) step(1'b0, 8, 3, 0);

        // Asynchronous reset while lit
        for (int i = 0; i < 12; i++) step(1'b1, 7, 10, 10);
        run_to_pos(4, 7, 10, 10);
        check_outputs();
        rst = 1'b1;
        #1;
        model_reset();
        chk("rst_led_r", led_r, 1'b1);
        chk("rst_led_g", led_g, 1'b1);
        chk("rst_led_b", led_b, 1'b1);
        chk("rst_busy", busy, 1'b0);
        chk("rst_period_start", period_start, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 5; i++) step(1'b0, 7, 10, 10);
        for (int i = 0; i < 15; i++) step(1'b1, 7, 10, 10);

        // Random traffic
        r = 3; g = 8; b = 12; e = 1'b1;
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 9) == 0) e = ~e;
            if ($urandom_range(0, 4) == 0) r = $urandom_range(0, 15);
            if ($urandom_range(0, 4) == 0) g = $urandom_range(0, 15);
            if ($urandom_range(0, 4) == 0) b = $urandom_range(0, 15);
            step(e, r, g, b);
        end
        for (int i = 0; i < 25; i++) step(1'b0, r, g, b);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/rgb_pwm_driver.md
# rgb_pwm_driver

Three-channel PWM output stage for the continuous colour wheel. It consumes the per-channel duty counts from the three fade instances and drives the RGB LED pins. Each channel is double-buffered so duty changes take effect only at period boundaries. An enable/drain state machine lets the wheel start and stop without truncating a PWM period.

## Interface
- PWM_INTERVAL, 1200: period in clk cycles (100 us at 12 MHz); must be ≥ 2.
- ACTIVE_LOW, 1: 1 means an LED pin is driven 0 when lit; 0 means driven 1 when lit.
- DW, $clog2(PWM_INTERVAL): duty/counter width (derived; 11 for the default).

Ports:
- clk  in  1  system clock.
- rst  in  1  reset, asynchronous and active-high.
- enable  in  1  request to run PWM.
- duty_r, duty_g, duty_b  in  DW each  requested on-cycles per period, sampled only at period start.
- led_r, led_g, led_b  out  1 each  registered PWM pins, polarity per ACTIVE_LOW.
- period_start  out  1  one-cycle strobe marking the first output cycle of each period.
- busy  out  1  high whenever state ≠ IDLE.

## Operation
- States:
  - IDLE: counter cnt held at 0; LEDs at inactive level.
  - RUN: PWM active.
  - DRAIN: PWM active; stops at end of the current period.
- Transitions, evaluated each clk:
  - IDLE & enable → RUN. On that edge: cnt←0 and shadow_k←clamp(duty_k).
  - RUN & !enable → DRAIN. cnt continues counting.
  - DRAIN & enable → RUN, with no gap or reset of cnt.
  - DRAIN & !enable & cnt==PWM_INTERVAL-1 → IDLE. cnt←0; shadows keep their values.
- Counter in RUN/DRAIN: cnt←cnt+1, wrapping PWM_INTERVAL-1→0.
- Shadow load: on the wrap edge, shadow_k←clamp(duty_k), but only if the next state is RUN or DRAIN. Shadows also load on IDLE→RUN entry. They load at no other time.
- Clamp: clamp(d) = d if d < PWM_INTERVAL, else PWM_INTERVAL.
- Compare: on_k = (state≠IDLE) && (cnt < shadow_k).
  - shadow 0: never lit.
  - shadow PWM_INTERVAL: lit for the whole period.
- Output register: led_k ← on_k XOR ACTIVE_LOW.
- Period strobe: period_start ← (state≠IDLE) && (cnt==0).
- busy is combinational from state.

## Timing
- Reset values (async): state IDLE, cnt 0, shadows 0, period_start 0, busy 0. led_k = ACTIVE_LOW, i.e. inactive (1 for the default).
- Reset mid-period: all outputs go to their reset values immediately, without waiting for a clock edge.
- Output latency: led_k and period_start in cycle t+1 reflect cnt, shadow and state in cycle t (one cycle).
- Start latency: enable first high in cycle t → busy high in t+1 → period_start and the first lit cycle in t+2.
- Duty update: a change to duty_k applied mid-period has no effect until the next wrap edge. This guarantees no glitch or partial pulse.
- Each channel is lit for exactly shadow_k consecutive cycles starting at the period_start cycle, then dark for PWM_INTERVAL-shadow_k cycles.
- Stop:
  - enable dropped in any cycle of a period: that period completes in full.
  - busy falls on the edge after cnt==PWM_INTERVAL-1.
  - LEDs go inactive one cycle later.
- Enable pulsing: enable low for one cycle, then high again within the same period → no visible change on any output except busy staying high.
- Simultaneous wrap and enable drop: the shadows load, and the new period runs in DRAIN.
- Continuous-high and continuous-low channels: no edges between periods (output stays constant across the wrap).

## Test plan
Use PWM_INTERVAL=10, ACTIVE_LOW=1.
- Reset, then enable=1 with duty_r=3, duty_g=0, duty_b=10:
  - led_r low for 3 cycles, high for 7, repeating.
  - led_g constantly 1.
  - led_b constantly 0.
  - period_start pulses every 10 cycles, first pulse 2 cycles after enable.
- duty_r changed 3→7 at cnt==4 → current period keeps 3 lit cycles; next period shows 7.
- duty_g=15 (over range) → clamped, lit all 10 cycles; no 1-cycle dark gap at the wrap.
- Drop enable at cnt==2:
  - the period finishes; busy falls after cnt==9.
  - all LEDs return to 1; no further period_start.
  - re-enable → restarts cleanly.
- enable low for exactly one cycle at cnt==5, then high → output waveform identical to an uninterrupted run.
- Assert rst at cnt==4 while lit → all LEDs go 1 and busy goes 0 asynchronously. After release, nothing happens until enable is sampled high.
